fnd_scan_controller: RTL and testbench

Parametrised multiplexed seven-segment (FND) scan controller driving a `DIGITS`-wide common-anode display from one packed BCD word. It owns the refresh timing: a prescaler produces one digit slot per `TICK_DIV` clocks and scans the digits round-robin. On top of that it provides load-time capture, leading-zero blanking, per-digit decimal points, per-digit blinking and a frame strobe. It sits between the calculator datapath (the BCD result) and the board FND pins, replacing the hand-driven digit-select/decoder pair.

---
 rtl/fnd_pkg.sv | 31 +++
 rtl/bcd_font_rom.sv | 26 ++
 rtl/fnd_scan_controller.sv | 141 ++++++++++++++
 tb/tb_fnd_scan_controller.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared constants for the FND scan controller: active-low segment fonts,
// special BCD codes and a width helper for the counters.
package fnd_pkg;

    // Fonts are {dp,g,f,e,d,c,b,a}, active-low, DP off.
    localparam logic [7:0] FONT_0    = 8'hC0;
    localparam logic [7:0] FONT_1    = 8'hF9;
    localparam logic [7:0] FONT_2    = 8'hA4;
    localparam logic [7:0] FONT_3    = 8'hB0;
    localparam logic [7:0] FONT_4    = 8'h99;
    localparam logic [7:0] FONT_5    = 8'h92;
    localparam logic [7:0] FONT_6    = 8'h82;
    localparam logic [7:0] FONT_7    = 8'hF8;
    localparam logic [7:0] FONT_8    = 8'h80;
    localparam logic [7:0] FONT_9    = 8'h90;
    localparam logic [7:0] FONT_DASH = 8'hBF;
    localparam logic [7:0] FONT_OFF  = 8'hFF;

    localparam logic [3:0] CODE_DASH = 4'd10;

    // Never returns less than 1 so degenerate counters still get a real register.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 1;
        while ((32'd1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/bcd_font_rom.sv
// Combinational 4-bit code to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module bcd_font_rom
    import fnd_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);

    always_comb begin
        case (i_code)
            4'd0:      o_seg = FONT_0[6:0];
            4'd1:      o_seg = FONT_1[6:0];
            4'd2:      o_seg = FONT_2[6:0];
            4'd3:      o_seg = FONT_3[6:0];
            4'd4:      o_seg = FONT_4[6:0];
            4'd5:      o_seg = FONT_5[6:0];
            4'd6:      o_seg = FONT_6[6:0];
            4'd7:      o_seg = FONT_7[6:0];
            4'd8:      o_seg = FONT_8[6:0];
            4'd9:      o_seg = FONT_9[6:0];
            CODE_DASH: o_seg = FONT_DASH[6:0];
            default:   o_seg = FONT_OFF[6:0];
        endcase
    end

endmodule

// File: rtl/fnd_scan_controller.sv
// Multiplexed common-anode FND scanner: prescaled round-robin digit scan with
// load-time capture, leading-zero blanking, decimal points, blinking and frame strobe.
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned TICK_DIV     = 100_000,
    parameter int unsigned BLINK_FRAMES = 128
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [4*DIGITS-1:0] i_value,
    input  logic                i_load,
    input  logic [DIGITS-1:0]   i_dp,
    input  logic [DIGITS-1:0]   i_blink_mask,
    input  logic                i_blank_lz,
    input  logic                i_en,
    output logic [DIGITS-1:0]   o_digit,
    output logic [7:0]          o_font,
    output logic                o_frame
);

    localparam int unsigned TickW  = clog2(TICK_DIV);
    localparam int unsigned IdxW   = clog2(DIGITS);
    localparam int unsigned FrameW = clog2(BLINK_FRAMES);

    localparam logic [TickW-1:0]  TickLast  = TickW'(TICK_DIV - 1);
    localparam logic [IdxW-1:0]   IdxLast   = IdxW'(DIGITS - 1);
    localparam logic [FrameW-1:0] FrameLast = FrameW'(BLINK_FRAMES - 1);

    logic [TickW-1:0]    r_tick_cnt;
    logic [IdxW-1:0]     r_idx;
    logic [FrameW-1:0]   r_frame_cnt;
    logic                r_blink_phase;
    logic [4*DIGITS-1:0] r_value;
    logic [DIGITS-1:0]   r_dp;
    logic [DIGITS-1:0]   r_blink_mask;
    logic [DIGITS-1:0]   r_digit;
    logic [7:0]          r_font;
    logic                r_frame;

    logic                w_tick;
    logic                w_wrap;
    logic [DIGITS-1:0]   w_lz_mask;
    logic                w_zero_run;
    logic [3:0]          w_code;
    logic                w_sel_dp;
    logic                w_sel_blink;
    logic                w_sel_lz;
    logic [6:0]          w_seg;
    logic                w_suppress;
    logic [DIGITS-1:0]   w_onehot;
    logic [DIGITS-1:0]   w_digit_d;
    logic [7:0]          w_font_d;

    assign w_tick = (r_tick_cnt == TickLast);
    assign w_wrap = w_tick && (r_idx == IdxLast);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tick_cnt    <= '0;
            r_idx         <= '0;
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_value       <= '0;
            r_dp          <= '0;
            r_blink_mask  <= '0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            if (w_tick) begin
                r_idx <= w_wrap ? '0 : r_idx + 1'b1;
            end
            if (w_wrap) begin
                r_frame_cnt <= (r_frame_cnt == FrameLast) ? '0 : r_frame_cnt + 1'b1;
                if (r_frame_cnt == FrameLast) begin
                    r_blink_phase <= ~r_blink_phase;
                end
            end
            if (i_load) begin
                r_value      <= i_value;
                r_dp         <= i_dp;
                r_blink_mask <= i_blink_mask;
            end
        end
    end

    // Digit k is a leading zero when it and every digit above it hold zero.
    always_comb begin
        w_zero_run = 1'b1;
        w_lz_mask  = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            w_zero_run   = w_zero_run & (r_value[4*k +: 4] == 4'd0);
            w_lz_mask[k] = w_zero_run;
        end
    end

    always_comb begin
        w_code      = 4'd0;
        w_sel_dp    = 1'b0;
        w_sel_blink = 1'b0;
        w_sel_lz    = 1'b0;
        w_onehot    = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_idx == IdxW'(k)) begin
                w_code      = r_value[4*k +: 4];
                w_sel_dp    = r_dp[k];
                w_sel_blink = r_blink_mask[k];
                w_sel_lz    = w_lz_mask[k];
                w_onehot[k] = 1'b0;
            end
        end
    end

    bcd_font_rom u_font_rom (
        .i_code (w_code),
        .o_seg  (w_seg)
    );

    always_comb begin
        w_suppress = !i_en || (r_blink_phase && w_sel_blink) || (i_blank_lz && w_sel_lz);
        w_digit_d  = w_suppress ? '1 : w_onehot;
        w_font_d   = w_suppress ? FONT_OFF : {~w_sel_dp, w_seg};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_digit <= '1;
            r_font  <= FONT_OFF;
            r_frame <= 1'b0;
        end else begin
            r_digit <= w_digit_d;
            r_font  <= w_font_d;
            r_frame <= w_wrap;
        end
    end

    assign o_digit = r_digit;
    assign o_font  = r_font;
    assign o_frame = r_frame;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Bench for fnd_scan_controller: elapsed-time display model checked every cycle,
// plus directed scenarios with hand-computed slot expectations.
module tb_fnd_scan_controller;

    localparam int ND = 4;
    localparam int TD = 4;
    localparam int BF = 2;

    logic          clk;
    logic          i_reset;
    logic [15:0]   i_value;
    logic          i_load;
    logic [3:0]    i_dp;
    logic [3:0]    i_blink_mask;
    logic          i_blank_lz;
    logic          i_en;
    logic [3:0]    o_digit;
    logic [7:0]    o_font;
    logic          o_frame;

    int checks = 0;
    int errors = 0;

    fnd_scan_controller #(
        .DIGITS       (ND),
        .TICK_DIV     (TD),
        .BLINK_FRAMES (BF)
    ) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_value      (i_value),
        .i_load       (i_load),
        .i_dp         (i_dp),
        .i_blink_mask (i_blink_mask),
        .i_blank_lz   (i_blank_lz),
        .i_en         (i_en),
        .o_digit      (o_digit),
        .o_font       (o_font),
        .o_frame      (o_frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] exp_seg(input int code);
        case (code)
            0:       return 7'h40;
            1:       return 7'h79;
            2:       return 7'h24;
            3:       return 7'h30;
            4:       return 7'h19;
            5:       return 7'h12;
            6:       return 7'h02;
            7:       return 7'h78;
            8:       return 7'h00;
            9:       return 7'h10;
            10:      return 7'h3F;
            default: return 7'h7F;
        endcase
    endfunction

    // Model: display state is a pure function of cycles elapsed since reset.
    int          m_c = 0;
    logic [15:0] m_val = '0;
    logic [3:0]  m_dp = '0;
    logic [3:0]  m_bm = '0;
    bit          m_valid = 1'b0;
    logic [3:0]  exp_digit = 4'hF;
    logic [7:0]  exp_font = 8'hFF;
    logic        exp_frame = 1'b0;
    int          mi_idx;
    int          mi_phase;
    bit          mi_lz;
    bit          mi_sup;

    initial begin
        forever begin
            @(posedge clk);
            if (i_reset) begin
                m_valid   = 1'b1;
                m_c       = 0;
                m_val     = '0;
                m_dp      = '0;
                m_bm      = '0;
                exp_digit = 4'hF;
                exp_font  = 8'hFF;
                exp_frame = 1'b0;
            end else if (m_valid) begin
                mi_idx    = (m_c / TD) % ND;
                mi_phase  = ((m_c / (TD * ND)) / BF) % 2;
                mi_lz     = i_blank_lz && (mi_idx != 0) && ((m_val >> (4 * mi_idx)) == 16'h0);
                mi_sup    = !i_en || (mi_phase == 1 && m_bm[mi_idx]) || mi_lz;
                exp_digit = mi_sup ? 4'hF : ~(4'b0001 << mi_idx);
                exp_font  = mi_sup ? 8'hFF
                          : {~m_dp[mi_idx], exp_seg(int'((m_val >> (4 * mi_idx)) & 16'hF))};
                exp_frame = ((m_c + 1) % (TD * ND)) == 0;
                m_c++;
                if (i_load) begin
                    m_val = i_value;
                    m_dp  = i_dp;
                    m_bm  = i_blink_mask;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (m_valid) begin
                chk("model_digit", {28'd0, o_digit}, {28'd0, exp_digit});
                chk("model_font", {24'd0, o_font}, {24'd0, exp_font});
                chk("model_frame", {31'd0, o_frame}, {31'd0, exp_frame});
            end
        end
    end

    task automatic load(input logic [15:0] val, input logic [3:0] dp, input logic [3:0] bm);
        @(negedge clk);
        i_value      = val;
        i_dp         = dp;
        i_blink_mask = bm;
        i_load       = 1'b1;
        @(negedge clk);
        i_load       = 1'b0;
    endtask

    task automatic sync_frame();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (o_frame !== 1'b1 && n < 40);
        chk("frame_seen", {31'd0, o_frame}, 32'd1);
    endtask

    // Called right after sync_frame; samples the middle of each digit slot.
    task automatic check_frame(input logic [15:0] ed, input logic [31:0] ef);
        for (int k = 0; k < 4; k++) begin
            repeat ((k == 0) ? 2 : 4) @(negedge clk);
            chk("slot_digit", {28'd0, o_digit}, {28'd0, ed[4*k +: 4]});
            chk("slot_font", {24'd0, o_font}, {24'd0, ef[8*k +: 8]});
        end
    endtask

    task automatic pin(input logic [3:0] d, input logic [7:0] f);
        chk("pin_digit", {28'd0, o_digit}, {28'd0, d});
        chk("pin_font", {24'd0, o_font}, {24'd0, f});
    endtask

    initial begin
        i_reset      = 1'b1;
        i_value      = '0;
        i_load       = 1'b0;
        i_dp         = '0;
        i_blink_mask = '0;
        i_blank_lz   = 1'b0;
        i_en         = 1'b1;
        repeat (3) @(negedge clk);
        pin(4'hF, 8'hFF);
        chk("reset_frame", {31'd0, o_frame}, 32'd0);

        // Scan 1234 from reset release.
        i_reset = 1'b0;
        i_value = 16'h1234;
        i_load  = 1'b1;
        @(negedge clk);
        i_load = 1'b0;
        pin(4'hE, 8'hC0);
        repeat (2) @(negedge clk);
        pin(4'hE, 8'h99);
        repeat (3) @(negedge clk);
        pin(4'hD, 8'hB0);
        repeat (4) @(negedge clk);
        pin(4'hB, 8'hA4);
        repeat (4) @(negedge clk);
        pin(4'h7, 8'hF9);
        repeat (2) @(negedge clk);
        chk("first_frame", {31'd0, o_frame}, 32'd1);
        @(negedge clk);
        chk("frame_single", {31'd0, o_frame}, 32'd0);
        sync_frame();
        check_frame(16'h7BDE, 32'hF9A4B099);

        // Leading-zero blanking.
        i_blank_lz = 1'b1;
        load(16'h0050, 4'b0000, 4'b0000);
        sync_frame();
        check_frame(16'hFFDE, 32'hFFFF92C0);
        load(16'h0000, 4'b0000, 4'b0000);
        sync_frame();
        check_frame(16'hFFFE, 32'hFFFFFFC0);

        // Special codes and decimal point.
        load(16'hA0B7, 4'b0100, 4'b0000);
        sync_frame();
        check_frame(16'h7BDE, 32'hBF40FFF8);

        // Blink from a fresh reset so frame numbers are known.
        @(negedge clk);
        i_reset    = 1'b1;
        i_blank_lz = 1'b0;
        repeat (2) @(negedge clk);
        i_reset      = 1'b0;
        i_value      = 16'h1234;
        i_dp         = 4'b0000;
        i_blink_mask = 4'b0001;
        i_load       = 1'b1;
        @(negedge clk);
        i_load = 1'b0;
        pin(4'hE, 8'hC0);
        repeat (18) @(negedge clk);
        pin(4'hE, 8'h99);
        repeat (16) @(negedge clk);
        pin(4'hF, 8'hFF);
        repeat (4) @(negedge clk);
        pin(4'hD, 8'hB0);
        repeat (12) @(negedge clk);
        pin(4'hF, 8'hFF);
        repeat (16) @(negedge clk);
        pin(4'hE, 8'h99);
        repeat (16) @(negedge clk);
        pin(4'hE, 8'h99);
        repeat (16) @(negedge clk);
        pin(4'hF, 8'hFF);

        // Reset during digit 2's slot.
        sync_frame();
        repeat (10) @(negedge clk);
        pin(4'hB, 8'hA4);
        i_reset = 1'b1;
        @(negedge clk);
        pin(4'hF, 8'hFF);
        i_reset = 1'b0;
        @(negedge clk);
        pin(4'hE, 8'hC0);
        repeat (3) @(negedge clk);
        pin(4'hE, 8'hC0);
        @(negedge clk);
        pin(4'hD, 8'hC0);

        // Load coincident with tick.
        load(16'h1234, 4'b0000, 4'b0000);
        sync_frame();
        repeat (3) @(negedge clk);
        i_value = 16'h9999;
        i_load  = 1'b1;
        @(negedge clk);
        i_load = 1'b0;
        pin(4'hE, 8'h99);
        @(negedge clk);
        pin(4'hD, 8'h90);
        i_value = 16'h0000;
        sync_frame();
        check_frame(16'h7BDE, 32'h90909090);

        // Display disable keeps the scan running.
        @(negedge clk);
        i_en = 1'b0;
        @(negedge clk);
        pin(4'hF, 8'hFF);
        sync_frame();
        pin(4'hF, 8'hFF);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
